// File: rtl/stf_seq_ctrl_if.sv
// Sample stream between the STF sequencer and the preamble/sample mux.
// The master drives the sample, valid and last flags; the slave returns ready.
interface stf_seq_ctrl_if;
   logic [31:0] stf_iq;
   logic        stf_valid;
   logic        stf_ready;
   logic        stf_last;

   modport master (output stf_iq, output stf_valid, output stf_last, input stf_ready);
   modport slave  (input stf_iq, input stf_valid, input stf_last, output stf_ready);
endinterface

// File: rtl/stf_seq_ctrl.sv
// Plays the 16-entry STF ROM REP_NUM times as a registered valid/ready stream.
// Define STF_WINDOW_EN to halve sample 0 and append a halved tail sample (state TAIL).
module stf_seq_ctrl #(
   parameter int REP_NUM = 10,
   parameter int ADDR_W  = 4
) (
   input  logic              clk,
   input  logic              phy_tx_arest,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_dout,
   stf_seq_ctrl_if.master    stf,
   output logic              busy,
   output logic              done
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
`ifdef STF_WINDOW_EN
   localparam logic [1:0] ST_TAIL = 2'd2;
`endif
   localparam logic [3:0] REP_LAST = 4'(REP_NUM - 1);

   logic [1:0]        state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [3:0]        rep_reg, rep_next;
   logic [31:0]       iq_reg, iq_next;
   logic              valid_reg, valid_next;
   logic              last_reg, last_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;
   logic              xfer;
   logic              addr_wrap;
   logic              burst_end;
   logic [31:0]       edge_sample;

   assign xfer      = valid_reg & stf.stf_ready;
   assign addr_wrap = (addr_reg == '1);

   // Edge samples use ROM entry 0; with windowing I and Q are halved independently (signed floor).
`ifdef STF_WINDOW_EN
   assign edge_sample = {rom_dout[31], rom_dout[31:17], rom_dout[15], rom_dout[15:1]};
`else
   assign edge_sample = rom_dout;
`endif

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      rep_next   = rep_reg;
      iq_next    = iq_reg;
      valid_next = valid_reg;
      last_next  = last_reg;
      busy_next  = busy_reg;
      done_next  = 1'b0;
      burst_end  = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            addr_next = '0;
            // The done cycle still counts as busy for start acceptance.
            if (start && !done_reg) begin
               state_next = ST_RUN;
               iq_next    = edge_sample;
               valid_next = 1'b1;
               busy_next  = 1'b1;
               last_next  = 1'b0;
               addr_next  = ADDR_W'(1);
               rep_next   = '0;
            end
         end
         ST_RUN: begin
            if (xfer) begin
               if (last_reg) begin
`ifdef STF_WINDOW_EN
                  state_next = ST_TAIL;
                  iq_next    = edge_sample;
                  last_next  = 1'b1;
`else
                  burst_end  = 1'b1;
`endif
               end else begin
                  iq_next   = rom_dout;
                  addr_next = addr_reg + 1'b1;
                  last_next = addr_wrap && (rep_reg == REP_LAST);
                  if (addr_wrap) begin
                     rep_next = rep_reg + 1'b1;
                  end
               end
            end
         end
`ifdef STF_WINDOW_EN
         ST_TAIL: begin
            if (xfer) begin
               burst_end = 1'b1;
            end
         end
`endif
         default: state_next = ST_IDLE;
      endcase

      if (burst_end) begin
         state_next = ST_IDLE;
         valid_next = 1'b0;
         last_next  = 1'b0;
         busy_next  = 1'b0;
         addr_next  = '0;
         done_next  = 1'b1;
      end

      if (abort) begin
         state_next = ST_IDLE;
         valid_next = 1'b0;
         last_next  = 1'b0;
         busy_next  = 1'b0;
         addr_next  = '0;
         rep_next   = '0;
         done_next  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge phy_tx_arest) begin
      if (phy_tx_arest) begin
         state_reg <= ST_IDLE;
         addr_reg  <= '0;
         rep_reg   <= '0;
         iq_reg    <= '0;
         valid_reg <= 1'b0;
         last_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         rep_reg   <= rep_next;
         iq_reg    <= iq_next;
         valid_reg <= valid_next;
         last_reg  <= last_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   assign rom_addr      = addr_reg;
   assign stf.stf_iq    = iq_reg;
   assign stf.stf_valid = valid_reg;
   assign stf.stf_last  = last_reg;
   assign busy          = busy_reg;
   assign done          = done_reg;
endmodule

// File: tb/tb_stf_seq_ctrl.sv
// Self-checking bench for stf_seq_ctrl: index-based reference model, stall/abort/reset corners.
// Build with STF_WINDOW_EN defined to exercise the windowed variant.
module tb_stf_seq_ctrl;
   localparam int REP = 10;
`ifdef STF_WINDOW_EN
   localparam bit WIN = 1'b1;
`else
   localparam bit WIN = 1'b0;
`endif
   localparam int N = 16 * REP + (WIN ? 1 : 0);

   typedef struct {
      int          idx;
      logic [31:0] iq;
      logic        last;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [3:0]  rom_addr;
   logic [31:0] rom_dout;
   logic        busy;
   logic        done;
   logic [31:0] rom_tbl [16];
   logic [31:0] cap_iq [$];
   logic        cap_last [$];
   vec_t        tbl [$];
   int          checks = 0;
   int          errors = 0;

   stf_seq_ctrl_if sif ();

   stf_seq_ctrl #(.REP_NUM(REP), .ADDR_W(4)) dut (
      .clk          (clk),
      .phy_tx_arest (rst),
      .start        (start),
      .abort        (abort),
      .rom_addr     (rom_addr),
      .rom_dout     (rom_dout),
      .stf          (sif.master),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   assign rom_dout = rom_tbl[rom_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [15:0] half16(input logic [15:0] x);
      logic signed [15:0] s;
      s = x;
      return s >>> 1;
   endfunction

   // Reference: sample k of the burst is ROM[k mod 16]; edges are halved when windowed.
   function automatic logic [31:0] exp_sample(input int k);
      logic [31:0] base;
      base = rom_tbl[k % 16];
      if (WIN && (k == 0 || k == N - 1)) begin
         return {half16(base[31:16]), half16(base[15:0])};
      end
      return base;
   endfunction

   task automatic burst(input string tag, input int rdy_pct, input int abort_at, input bit poke);
      int          n;
      bit          fin;
      bit          prev_stall;
      logic [31:0] prev_iq;
      logic        prev_last;
      logic [3:0]  prev_addr;
      n = 0;
      fin = 1'b0;
      prev_stall = 1'b0;
      prev_iq = '0;
      prev_last = 1'b0;
      prev_addr = '0;
      cap_iq.delete();
      cap_last.delete();
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, " first valid"}, 32'(sif.stf_valid), 32'd1);
      chk({tag, " busy"}, 32'(busy), 32'd1);
      for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
         start = 1'b0;
         if (prev_stall) begin
            chk({tag, " hold iq"}, sif.stf_iq, prev_iq);
            chk({tag, " hold last"}, 32'(sif.stf_last), 32'(prev_last));
            chk({tag, " hold addr"}, 32'(rom_addr), 32'(prev_addr));
         end
         prev_stall = 1'b0;
         chk({tag, " valid"}, 32'(sif.stf_valid), 32'd1);
         chk({tag, " done low"}, 32'(done), 32'd0);
         if (n == abort_at) begin
            abort = 1'b1;
            sif.stf_ready = 1'b0;
            step();
            abort = 1'b0;
            chk({tag, " abort valid"}, 32'(sif.stf_valid), 32'd0);
            chk({tag, " abort busy"}, 32'(busy), 32'd0);
            chk({tag, " abort last"}, 32'(sif.stf_last), 32'd0);
            chk({tag, " abort addr"}, 32'(rom_addr), 32'd0);
            for (int i = 0; i < 20; i++) begin
               chk({tag, " abort no done"}, 32'(done), 32'd0);
               step();
            end
            fin = 1'b1;
         end else begin
            sif.stf_ready = (rdy_pct >= 100) || ($urandom_range(99) < rdy_pct);
            if (sif.stf_ready) begin
               chk({tag, " iq"}, sif.stf_iq, exp_sample(n));
               chk({tag, " last"}, 32'(sif.stf_last), 32'(n == N - 1));
               if (rdy_pct >= 100) chk({tag, " no bubble"}, 32'(cyc), 32'(n));
               cap_iq.push_back(sif.stf_iq);
               cap_last.push_back(sif.stf_last);
               n++;
            end else begin
               prev_stall = 1'b1;
               prev_iq = sif.stf_iq;
               prev_last = sif.stf_last;
               prev_addr = rom_addr;
            end
            if (poke && n == 37) start = 1'b1;
            step();
            start = 1'b0;
            if (n == N) begin
               chk({tag, " end valid"}, 32'(sif.stf_valid), 32'd0);
               chk({tag, " end busy"}, 32'(busy), 32'd0);
               chk({tag, " done"}, 32'(done), 32'd1);
               chk({tag, " end addr"}, 32'(rom_addr), 32'd0);
               if (poke) start = 1'b1;
               step();
               start = 1'b0;
               chk({tag, " done pulse"}, 32'(done), 32'd0);
               for (int i = 0; i < 3; i++) begin
                  chk({tag, " idle valid"}, 32'(sif.stf_valid), 32'd0);
                  chk({tag, " idle busy"}, 32'(busy), 32'd0);
                  step();
               end
               fin = 1'b1;
            end
         end
      end
      if (!fin) chk({tag, " timeout"}, 32'd0, 32'd1);
      sif.stf_ready = 1'b0;
      $display("burst %s: %0d transfers", tag, n);
   endtask

   initial begin
      rom_tbl = '{32'hfd0e_fd0e, 32'hfbd6_0000, 32'h0123_f456, 32'h0789_ff12,
                  32'h05e0_0000, 32'h0789_ff13, 32'h0124_f457, 32'h0000_fbd6,
                  32'h0444_0111, 32'hf00f_1234, 32'h8000_7fff, 32'h0001_ffff,
                  32'h7fff_8001, 32'h1357_9bdf, 32'hfffe_0003, 32'h0000_fbd6};
`ifdef STF_WINDOW_EN
      tbl.push_back('{0,   32'hfe87_fe87, 1'b0});
      tbl.push_back('{159, 32'h0000_fbd6, 1'b0});
      tbl.push_back('{160, 32'hfe87_fe87, 1'b1});
`else
      tbl.push_back('{0,   32'hfd0e_fd0e, 1'b0});
      tbl.push_back('{159, 32'h0000_fbd6, 1'b1});
`endif
      tbl.push_back('{1,   32'hfbd6_0000, 1'b0});
      tbl.push_back('{7,   32'h0000_fbd6, 1'b0});
      tbl.push_back('{16,  32'hfd0e_fd0e, 1'b0});
      tbl.push_back('{158, 32'hfffe_0003, 1'b0});

      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      sif.stf_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset valid", 32'(sif.stf_valid), 32'd0);
      chk("reset iq", sif.stf_iq, 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset addr", 32'(rom_addr), 32'd0);
      rst = 1'b0;
      step();

      burst("ready_high", 100, -1, 1'b0);
      chk("burst length", 32'(cap_iq.size()), 32'(N));
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].idx < cap_iq.size()) begin
            chk($sformatf("table s%0d iq", tbl[i].idx), cap_iq[tbl[i].idx], tbl[i].iq);
            chk($sformatf("table s%0d last", tbl[i].idx), 32'(cap_last[tbl[i].idx]), 32'(tbl[i].last));
         end else begin
            chk($sformatf("table s%0d missing", tbl[i].idx), 32'(cap_iq.size()), 32'(tbl[i].idx + 1));
         end
      end

      burst("ready_rand_a", 50, -1, 1'b0);
      burst("ready_rand_b", 50, -1, 1'b0);
      burst("abort_50", 70, 50, 1'b0);
      burst("after_abort", 100, -1, 1'b0);
      burst("start_poke", 100, -1, 1'b1);

      // abort and start together in IDLE: nothing starts
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      chk("abort+start valid", 32'(sif.stf_valid), 32'd0);
      chk("abort+start busy", 32'(busy), 32'd0);
      step();

      // asynchronous reset in the middle of a burst
      start = 1'b1;
      step();
      start = 1'b0;
      sif.stf_ready = 1'b1;
      repeat (30) step();
      #2 rst = 1'b1;
      #1;
      chk("arst valid", 32'(sif.stf_valid), 32'd0);
      chk("arst iq", sif.stf_iq, 32'd0);
      chk("arst last", 32'(sif.stf_last), 32'd0);
      chk("arst busy", 32'(busy), 32'd0);
      chk("arst addr", 32'(rom_addr), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("arst no done", 32'(done), 32'd0);
         chk("arst stays idle", 32'(sif.stf_valid), 32'd0);
      end
      sif.stf_ready = 1'b0;
      $display("burst arst_mid: reset after 30 cycles");

      burst("after_reset", 50, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
